// File: rtl/frame_tx_scheduler.sv
// Round-robin frame scheduler: CLR -> HDR -> DATA -> CRC -> GAP, every output registered; grant appears 1 cycle after REQ.
// Optional VALID-low watchdog in DATA (ABORT state) is built when FRM_SCHED_TIMEOUT_EN is defined.
module frame_tx_scheduler #(
   parameter int NREQ      = 4,
   parameter int HDR_WORDS = 4,
   parameter int CRC_WORDS = 2,
   parameter int MAX_DATA  = 800,
   parameter int IFG       = 4,
   parameter int TMO       = 64
) (
   input  logic            CLK,
   input  logic            rst_rom_addr,
   input  logic [NREQ-1:0] REQ,
   input  logic [NREQ-1:0] VALID,
   output logic [NREQ-1:0] GNT,
   output logic [2:0]      SEL,
   output logic [2:0]      ROM_ADDR,
   output logic            CLR_CRC,
   output logic            CRC_DV,
   output logic [1:0]      DATA_SRC,
   output logic            TX_ACK,
   output logic            TRUNC,
   output logic            ABORT,
   output logic [3:0]      FRM_STATE
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_CLR   = 4'd1,
      S_HDR   = 4'd2,
      S_DATA  = 4'd3,
      S_CRC   = 4'd4,
      S_GAP   = 4'd5,
      S_ABORT = 4'd6
   } state_t;

   localparam logic [1:0] SRC_FILL = 2'd0;
   localparam logic [1:0] SRC_ROM  = 2'd1;
   localparam logic [1:0] SRC_DATA = 2'd2;
   localparam logic [1:0] SRC_CRC  = 2'd3;

   // One counter serves CRC words, gap cycles and the DATA wait watchdog.
   localparam int SUB_MAX = (TMO > 15) ? TMO : 15;
   localparam int SUB_W   = $clog2(SUB_MAX + 1);

   state_t            state, n_state;
   logic [1:0]        rst_sync;
   logic              rst;
   logic [2:0]        ptr_q, n_ptr;
   logic [9:0]        cnt_q, n_cnt;
   logic [SUB_W-1:0]  sub_q, n_sub;
   logic              tlat_q, n_tlat;
   logic [NREQ-1:0]   n_gnt;
   logic [2:0]        n_sel, n_rom, win, nxt_ptr;
   logic              n_clr, n_dv, n_ack, n_trunc, decide, v, hit_max;
   logic [1:0]        n_src;
   logic [2*NREQ-1:0] req_dbl;
   int                pick;
`ifdef FRM_SCHED_TIMEOUT_EN
   logic              abort_q, n_abort;
`endif

   // Reset asserts immediately and releases on the second clock edge.
   always_ff @(posedge CLK or posedge rst_rom_addr) begin
      if (rst_rom_addr) rst_sync <= 2'b11;
      else              rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst = rst_sync[1];

   // Doubled request vector: lowest set bit at/after the pointer wins.
   always_comb begin
      req_dbl = {REQ, REQ};
      pick    = 0;
      for (int i = 2*NREQ-1; i >= 0; i--) begin
         if (req_dbl[i] && (i >= int'(ptr_q))) pick = i;
      end
      win = 3'(pick % NREQ);
   end

   assign nxt_ptr = 3'((int'(SEL) + 1) % NREQ);
   assign v       = |(VALID & GNT);
   assign hit_max = (cnt_q == 10'(MAX_DATA));

   always_comb begin
      n_state = state;
      n_gnt   = GNT;
      n_sel   = SEL;
      n_rom   = '0;
      n_clr   = 1'b0;
      n_dv    = 1'b0;
      n_src   = SRC_FILL;
      n_ack   = 1'b0;
      n_trunc = 1'b0;
      n_ptr   = ptr_q;
      n_cnt   = cnt_q;
      n_sub   = sub_q;
      n_tlat  = tlat_q;
      decide  = 1'b0;
`ifdef FRM_SCHED_TIMEOUT_EN
      n_abort = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (|REQ) begin
               n_state = S_CLR;
               n_gnt   = NREQ'(1) << win;
               n_sel   = win;
               n_clr   = 1'b1;
               n_cnt   = '0;
               n_sub   = '0;
               n_tlat  = 1'b0;
            end
         end
         S_CLR: begin
            n_state = S_HDR;
            n_src   = SRC_ROM;
            n_dv    = 1'b1;
         end
         S_HDR: begin
            if (ROM_ADDR == 3'(HDR_WORDS-1)) begin
               decide = 1'b1;
            end else begin
               n_rom = ROM_ADDR + 3'd1;
               n_src = SRC_ROM;
               n_dv  = 1'b1;
            end
         end
         S_DATA: decide = 1'b1;
         S_CRC: begin
            if (sub_q == SUB_W'(CRC_WORDS-1)) begin
               n_state = S_GAP;
               n_gnt   = '0;
               n_ptr   = nxt_ptr;
               n_sub   = '0;
            end else begin
               n_sub   = sub_q + 1'b1;
               n_src   = SRC_CRC;
               n_ack   = (sub_q == SUB_W'(CRC_WORDS-2));
               n_trunc = n_ack & tlat_q;
            end
         end
         S_GAP: begin
            if (sub_q == SUB_W'(IFG-1)) n_state = S_IDLE;
            else                        n_sub   = sub_q + 1'b1;
         end
         S_ABORT: begin
            n_state = S_GAP;
            n_gnt   = '0;
            n_ptr   = nxt_ptr;
            n_sub   = '0;
         end
         default: n_state = S_IDLE;
      endcase

      // Data-phase decision, taken on the last header edge and every DATA edge.
      if (decide) begin
         if (hit_max || (!v && (cnt_q != '0))) begin
            n_state = S_CRC;
            n_src   = SRC_CRC;
            n_sub   = '0;
            n_tlat  = hit_max;
            n_ack   = (CRC_WORDS == 1);
            n_trunc = (CRC_WORDS == 1) && hit_max;
         end else if (v) begin
            n_state = S_DATA;
            n_src   = SRC_DATA;
            n_dv    = 1'b1;
            n_cnt   = cnt_q + 10'd1;
         end else begin
`ifdef FRM_SCHED_TIMEOUT_EN
            if (sub_q == SUB_W'(TMO)) begin
               n_state = S_ABORT;
               n_abort = 1'b1;
            end else begin
               n_state = S_DATA;
               n_src   = SRC_DATA;
               n_sub   = sub_q + 1'b1;
            end
`else
            n_state = S_DATA;
            n_src   = SRC_DATA;
`endif
         end
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         GNT      <= '0;
         SEL      <= '0;
         ROM_ADDR <= '0;
         CLR_CRC  <= 1'b0;
         CRC_DV   <= 1'b0;
         DATA_SRC <= SRC_FILL;
         TX_ACK   <= 1'b0;
         TRUNC    <= 1'b0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         sub_q    <= '0;
         tlat_q   <= 1'b0;
`ifdef FRM_SCHED_TIMEOUT_EN
         abort_q  <= 1'b0;
`endif
      end else begin
         state    <= n_state;
         GNT      <= n_gnt;
         SEL      <= n_sel;
         ROM_ADDR <= n_rom;
         CLR_CRC  <= n_clr;
         CRC_DV   <= n_dv;
         DATA_SRC <= n_src;
         TX_ACK   <= n_ack;
         TRUNC    <= n_trunc;
         ptr_q    <= n_ptr;
         cnt_q    <= n_cnt;
         sub_q    <= n_sub;
         tlat_q   <= n_tlat;
`ifdef FRM_SCHED_TIMEOUT_EN
         abort_q  <= n_abort;
`endif
      end
   end

   assign FRM_STATE = state;
`ifdef FRM_SCHED_TIMEOUT_EN
   assign ABORT = abort_q;
`else
   assign ABORT = 1'b0;
`endif

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Bench for frame_tx_scheduler: frame shape and grant order checked against a pattern-level model.
module tb_frame_tx_scheduler;
   localparam int NREQ = 4, HDR_WORDS = 4, CRC_WORDS = 2, MAX_DATA = 800, IFG = 4, TMO = 64;

   logic            CLK = 1'b0;
   logic            rst_rom_addr;
   logic [NREQ-1:0] REQ, VALID, GNT;
   logic [2:0]      SEL, ROM_ADDR;
   logic            CLR_CRC, CRC_DV, TX_ACK, TRUNC, ABORT;
   logic [1:0]      DATA_SRC;
   logic [3:0]      FRM_STATE;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;
   bit pat[$];

   always #5 CLK = ~CLK;

   frame_tx_scheduler #(
      .NREQ(NREQ), .HDR_WORDS(HDR_WORDS), .CRC_WORDS(CRC_WORDS),
      .MAX_DATA(MAX_DATA), .IFG(IFG), .TMO(TMO)
   ) dut (
      .CLK(CLK), .rst_rom_addr(rst_rom_addr), .REQ(REQ), .VALID(VALID),
      .GNT(GNT), .SEL(SEL), .ROM_ADDR(ROM_ADDR), .CLR_CRC(CLR_CRC),
      .CRC_DV(CRC_DV), .DATA_SRC(DATA_SRC), .TX_ACK(TX_ACK), .TRUNC(TRUNC),
      .ABORT(ABORT), .FRM_STATE(FRM_STATE)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // VALID samples for the owner lane: lead lows, then highs, then one low.
   task automatic make_pat(input int lead, input int ones);
      pat.delete();
      repeat (lead) pat.push_back(1'b0);
      repeat (ones) pat.push_back(1'b1);
      pat.push_back(1'b0);
   endtask

   // One complete frame; expected shape derived from the request vector and the VALID pattern.
   task automatic run_frame(input logic [NREQ-1:0] req, input bit drop_req);
      int win, waits, words, k, idx;
      int n_clr, n_hdr, n_data, n_dv, n_crc, n_ack, n_trunc, n_abort, n_gap, n_act;
      int rom_err, dv_err, pos_err, gnt_err;
      bit exp_trunc, b;
      logic [NREQ-1:0] exp_gnt, nz;
      win = 0;
      for (int i = NREQ-1; i >= 0; i--) if (req[(model_ptr+i)%NREQ]) win = (model_ptr+i)%NREQ;
      waits = 0;
      while (waits < pat.size() && !pat[waits]) waits++;
      words = 0;
      while (waits+words < pat.size() && words < MAX_DATA && pat[waits+words]) words++;
      exp_trunc = (words == MAX_DATA);
      exp_gnt = '0;
      exp_gnt[win] = 1'b1;

      REQ = req;
      VALID = '0;
      step();
      checks++; if (GNT !== exp_gnt) begin errors++; $display("FAIL grant: GNT=%b expected %b", GNT, exp_gnt); end
      checks++; if (SEL !== 3'(win)) begin errors++; $display("FAIL sel: SEL=%0d expected %0d", SEL, win); end
      checks++; if (FRM_STATE !== 4'd1) begin errors++; $display("FAIL clr_state: FRM_STATE=%0d expected 1", FRM_STATE); end
      if (drop_req) REQ = '0;

      n_clr = 0; n_hdr = 0; n_data = 0; n_dv = 0; n_crc = 0; n_ack = 0; n_trunc = 0;
      n_abort = 0; n_gap = 0; n_act = 0; rom_err = 0; dv_err = 0; pos_err = 0; gnt_err = 0;
      k = 0;
      while (FRM_STATE !== 4'd0 && k < 3000) begin
         if (CLR_CRC) n_clr++;
         if (CRC_DV) n_dv++;
         if (TX_ACK) n_ack++;
         if (TRUNC) n_trunc++;
         if (ABORT) n_abort++;
         if (FRM_STATE >= 4'd1 && FRM_STATE <= 4'd4) begin
            n_act++;
            if (GNT !== exp_gnt) gnt_err++;
         end
         if (FRM_STATE == 4'd5) begin
            n_gap++;
            if (GNT !== '0) gnt_err++;
         end
         case (DATA_SRC)
            2'd1: begin if (ROM_ADDR !== 3'(n_hdr)) rom_err++; n_hdr++; end
            2'd2: begin if (CRC_DV !== (n_data >= waits)) dv_err++; n_data++; end
            2'd3: begin
               if (CRC_DV) dv_err++;
               if (TX_ACK !== (n_crc == CRC_WORDS-1)) pos_err++;
               if (TRUNC !== (exp_trunc && n_crc == CRC_WORDS-1)) pos_err++;
               n_crc++;
            end
            default: if (CRC_DV) dv_err++;
         endcase
         idx = k - HDR_WORDS;
         b = (idx >= 0 && idx < pat.size()) ? pat[idx] : 1'b0;
         nz = NREQ'($urandom);
         nz[win] = b;
         VALID = nz;
         step();
         k++;
      end
      VALID = '0;
      checks++; if (k >= 3000) begin errors++; $display("FAIL frame_timeout: %0d cycles without IDLE, limit 3000", k); end
      checks++; if (n_clr !== 1) begin errors++; $display("FAIL clr_pulses: got %0d expected 1", n_clr); end
      checks++; if (n_hdr !== HDR_WORDS) begin errors++; $display("FAIL hdr_cycles: got %0d expected %0d", n_hdr, HDR_WORDS); end
      checks++; if (rom_err !== 0) begin errors++; $display("FAIL rom_addr_seq: %0d bad addresses expected 0", rom_err); end
      checks++; if (n_data !== waits+words) begin errors++; $display("FAIL data_cycles: got %0d expected %0d", n_data, waits+words); end
      checks++; if (n_dv !== HDR_WORDS+words) begin errors++; $display("FAIL crc_dv_count: got %0d expected %0d", n_dv, HDR_WORDS+words); end
      checks++; if (dv_err !== 0) begin errors++; $display("FAIL crc_dv_follow: %0d bad cycles expected 0", dv_err); end
      checks++; if (n_crc !== CRC_WORDS) begin errors++; $display("FAIL crc_cycles: got %0d expected %0d", n_crc, CRC_WORDS); end
      checks++; if (n_ack !== 1) begin errors++; $display("FAIL tx_ack_count: got %0d expected 1", n_ack); end
      checks++; if (n_trunc !== int'(exp_trunc)) begin errors++; $display("FAIL trunc_count: got %0d expected %0d", n_trunc, exp_trunc); end
      checks++; if (pos_err !== 0) begin errors++; $display("FAIL ack_position: %0d misplaced pulses expected 0", pos_err); end
      checks++; if (n_gap !== IFG) begin errors++; $display("FAIL gap_cycles: got %0d expected %0d", n_gap, IFG); end
      checks++; if (gnt_err !== 0) begin errors++; $display("FAIL gnt_hold: %0d bad cycles expected 0", gnt_err); end
      checks++; if (n_act !== 1+HDR_WORDS+waits+words+CRC_WORDS) begin
         errors++; $display("FAIL frame_length: got %0d expected %0d", n_act, 1+HDR_WORDS+waits+words+CRC_WORDS);
      end
      checks++; if (n_abort !== 0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", n_abort); end
      model_ptr = (win + 1) % NREQ;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      #1;
      checks++; if ({GNT, SEL, ROM_ADDR, CLR_CRC, CRC_DV, DATA_SRC, TX_ACK, TRUNC, ABORT, FRM_STATE} !== '0) begin
         errors++; $display("FAIL reset_outputs: GNT=%b SEL=%0d ROM=%0d SRC=%0d STATE=%0d expected all 0", GNT, SEL, ROM_ADDR, DATA_SRC, FRM_STATE);
      end
      REQ = '1;
      step();
      checks++; if (GNT !== '0) begin errors++; $display("FAIL reset_no_grant: GNT=%b expected 0", GNT); end
      REQ = '0;
      rst_rom_addr = 1'b0;
      repeat (4) step();
      checks++; if (FRM_STATE !== 4'd0 || GNT !== '0) begin
         errors++; $display("FAIL idle_after_reset: STATE=%0d GNT=%b expected 0 and 0", FRM_STATE, GNT);
      end
      model_ptr = 0;
   endtask

   task automatic test_round_robin();
      make_pat(0, 3);
      repeat (5) run_frame('1, 1'b0);
   endtask

   task automatic test_single_frame();
      make_pat(0, 10);
      run_frame(4'b0001, 1'b1);
   endtask

   task automatic test_gapped();
      make_pat(0, 1);
      pat.push_back(1'b1);
      run_frame(4'b1000, 1'b1);
      make_pat(2, 2);
      pat.push_back(1'b1);
      run_frame(4'b0010, 1'b0);
   endtask

   task automatic test_truncation();
      make_pat(0, 900);
      run_frame(4'b0100, 1'b1);
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         make_pat($urandom_range(0, 5), $urandom_range(1, 20));
         repeat (4) pat.push_back(1'($urandom));
         run_frame(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'($urandom));
      end
   endtask

   task automatic test_reset_mid_data();
      int acks;
      REQ = 4'b0100;
      VALID = 4'b0100;
      step();
      REQ = '0;
      repeat (HDR_WORDS + 2) step();
      checks++; if (FRM_STATE !== 4'd3 || CRC_DV !== 1'b1) begin
         errors++; $display("FAIL pre_reset_data: STATE=%0d DV=%b expected 3 and 1", FRM_STATE, CRC_DV);
      end
      #2 rst_rom_addr = 1'b1;
      #1;
      checks++; if ({GNT, SEL, ROM_ADDR, CLR_CRC, CRC_DV, DATA_SRC, TX_ACK, TRUNC, ABORT, FRM_STATE} !== '0) begin
         errors++; $display("FAIL midframe_reset: GNT=%b SRC=%0d STATE=%0d expected all 0", GNT, DATA_SRC, FRM_STATE);
      end
      VALID = '0;
      @(posedge CLK);
      #1 rst_rom_addr = 1'b0;
      acks = 0;
      repeat (8) begin
         step();
         if (TX_ACK) acks++;
      end
      checks++; if (acks !== 0) begin errors++; $display("FAIL no_ack_after_reset: got %0d expected 0", acks); end
      model_ptr = 0;
      make_pat(0, 2);
      run_frame('1, 1'b1);
   endtask

`ifdef FRM_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n_wait, n_abort, n_ack, n_gap, budget, bad_state;
      REQ = 4'b0010;
      VALID = '0;
      step();
      checks++; if (GNT !== 4'b0010) begin errors++; $display("FAIL tmo_grant: GNT=%b expected 0010", GNT); end
      REQ = '0;
      n_wait = 0; n_abort = 0; n_ack = 0; n_gap = 0; budget = 0; bad_state = 0;
      while (FRM_STATE !== 4'd5 && budget < 500) begin
         step();
         budget++;
         if (FRM_STATE == 4'd3) n_wait++;
         if (TX_ACK) n_ack++;
         if (ABORT) begin n_abort++; if (FRM_STATE !== 4'd6) bad_state++; end
      end
      while (FRM_STATE == 4'd5 && budget < 500) begin
         n_gap++;
         step();
         budget++;
      end
      checks++; if (budget >= 500) begin errors++; $display("FAIL tmo_budget: %0d cycles, limit 500", budget); end
      checks++; if (n_wait !== TMO) begin errors++; $display("FAIL tmo_wait: got %0d expected %0d", n_wait, TMO); end
      checks++; if (n_abort !== 1 || bad_state !== 0) begin errors++; $display("FAIL abort_pulse: got %0d (bad state %0d) expected 1", n_abort, bad_state); end
      checks++; if (n_ack !== 0) begin errors++; $display("FAIL tmo_no_ack: got %0d expected 0", n_ack); end
      checks++; if (n_gap !== IFG || FRM_STATE !== 4'd0) begin errors++; $display("FAIL tmo_gap: gap %0d state %0d expected %0d and 0", n_gap, FRM_STATE, IFG); end
      model_ptr = 2;
   endtask
`else
   task automatic test_timeout();
      make_pat(200, 2);
      run_frame(4'b0010, 1'b1);
   endtask
`endif

   initial begin
      rst_rom_addr = 1'b1;
      REQ = '0;
      VALID = '0;
      test_reset();
      test_round_robin();
      test_single_frame();
      test_gapped();
      test_truncation();
      test_random();
      test_reset_mid_data();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
